cpu_controller: RTL
===================

// Module: cpu_controller
// PURPOSE
//  Control half of the simple RISC CPU. Fetches 16-bit instructions, decodes them and sequences every datapath control (readnum/writenum/write/loada/loadb/asel/bsel/vsel/loadc/loads/shift/ALUop).
//  Also supplies sximm8/sximm5 and PC to the datapath. Drives the memory command/address.
//  Sits between instruction/data memory and the datapath; consumes the datapath result (datapath_out) for LDR/STR addresses.
// PARAMETERS
//  PC_W    8   program counter and memory address width; wraps 2^PC_W-1 -> 0
//  RST_PC  0   PC value loaded on reset
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  reset         in   1      synchronous, active-high; returns FSM to RST
//  read_data     in   16     memory read data; instruction source
//  datapath_out  in   16     datapath C register; [PC_W-1:0] loaded as data address
//  readnum       out  3      register read select
//  writenum      out  3      register write select
//  write         out  1      regfile write enable
//  loada         out  1      datapath A register load
//  loadb         out  1      datapath B register load
//  loadc         out  1      datapath C register load
//  loads         out  1      datapath status register load
//  asel          out  1      1 = zero into ALU A input
//  bsel          out  1      1 = sximm5 into ALU B input
//  vsel          out  2      writeback select: 00 mdata, 01 sximm8, 10 PC, 11 datapath_out
//  shift         out  2      shifter op = IR[4:3]; 00 where no shift is applied
//  ALUop         out  2      ALU op: 00 ADD, 01 SUB(CMP), 10 AND, 11 MVN
//  sximm8        out  16     sign-extended IR[7:0]
//  sximm5        out  16     sign-extended IR[4:0]
//  PC            out  PC_W   program counter
//  mem_cmd       out  2      00 NONE, 01 READ, 10 WRITE
//  mem_addr      out  PC_W   addr_sel ? PC : data_addr
//  halted        out  1      1 while in HALT state
// BEHAVIOUR
//  - IR fields: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] sh, [2:0] Rm.
//    Decodes: 110/10 MOV imm; 110/00 MOV reg; 101/xx ALU; 011/00 LDR; 100/00 STR; 111/00 HALT.
//    Any other encoding -> HALT.
//  - Reset (sync): state=RST, PC=RST_PC, IR=0, data_addr=0. All strobes 0, mem_cmd=NONE, halted=0.
//    Reset wins over any in-flight state. An STR aborted before MEM_WR never issues WRITE.
//  - Outputs are Moore: f(state, IR). Every strobe not listed below is 0.
//  - Memory: synchronous read; data is valid in the cycle after the address is presented.
//  - Fetch sequence: RST -> IF1 (addr_sel=1, READ) -> IF2 (addr_sel=1, READ, load IR) -> UPDATE_PC (PC<=PC+1, mod 2^PC_W) -> DECODE.
//  - MOV imm: WR_IMM (writenum=Rn, vsel=01, write) -> IF1.
//  - MOV reg: GET_B (readnum=Rm, loadb) -> ALU (asel=1, ALUop=00, shift=sh, loadc) -> WR_REG (writenum=Rd, vsel=11, write) -> IF1.
//  - ALU ops: GET_A (readnum=Rn, loada) -> GET_B -> ALU (ALUop=op, shift=sh, loadc).
//    MVN skips GET_A. CMP: ALU state asserts loads instead of loadc, then -> IF1 with no write.
//    Others continue ALU -> WR_REG.
//  - LDR: GET_A -> ADDR (asel=0, bsel=1, ALUop=00, loadc) -> LD_ADDR (data_addr<=datapath_out[PC_W-1:0])
//    -> RD1 (addr_sel=0, READ) -> RD2 (addr_sel=0, READ, writenum=Rd, vsel=00, write) -> IF1.
//  - STR: GET_A -> ADDR -> LD_ADDR -> GET_RD (readnum=Rd, loadb) -> PASS (asel=1, bsel=0, shift=00, ALUop=00, loadc)
//    -> MEM_WR (addr_sel=0, WRITE for exactly 1 cycle) -> IF1.
//  - HALT: self-loop, halted=1, PC frozen, mem_cmd=NONE; only reset exits.
//  - PC wrap: PC=2^PC_W-1 fetch -> PC=0 after UPDATE_PC.
// STRUCTURE
//  - cpu_pkg: state enum, opcode/op constants, MEM_NONE/READ/WRITE, VSEL_* codes, ALU_* codes.
//  - Sub-module inst_decoder (combinational): IR -> opcode, op, Rn/Rd/Rm, sh, sximm8, sximm5.
//  - IR, PC and data_addr registers use the team's vDFFE enable-register.
// TESTING
//  1. reset; fetch 0xD007 (MOV R0,#7) -> PC 0->1; WR_IMM: write=1, writenum=0, vsel=01, sximm8=0x0007.
//  2. 0xD1FE (MOV R1,#-2) -> sximm8=0xFFFE, writenum=1.
//  3. 0xA148 (ADD R2,R1,R0,LSL#1) -> readnum=1/loada; readnum=0/loadb, shift=01; ALUop=00, loadc; writenum=2, vsel=11, write.
//  4. 0xA801 (CMP R0,R1) -> loads=1, loadc=0 in ALU state; no write; next state IF1.
//  5. 0x6064 (LDR R3,[R0,#4]) with datapath_out=0x0014 -> bsel=1, sximm5=0x0004; mem_addr=0x14, READ for 2 cycles; write with writenum=3, vsel=00.
//     0x8062 (STR) -> exactly one WRITE cycle; reset asserted in PASS state -> no WRITE, PC=0.
//  6. 0xE000 and illegal 0xF800 -> halted=1, PC frozen for 20 cycles; reset -> halted=0, PC=0, IF1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the RISC CPU control half: FSM states,
// instruction field codes, memory/writeback/ALU codes and the control bundle.
package cpu_pkg;

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPDATE_PC, S_DECODE, S_WR_IMM,
    S_GET_A, S_GET_B, S_ALU, S_WR_REG,
    S_ADDR, S_LD_ADDR, S_RD1, S_RD2, S_GET_RD, S_PASS, S_MEM_WR,
    S_HALT
  } state_t;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] VSEL_MDATA = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b01;
  localparam logic [1:0] VSEL_PC    = 2'b10;
  localparam logic [1:0] VSEL_C     = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] sh;
    logic [15:0] sximm8;
    logic [15:0] sximm5;
  } dec_t;

  // Everything the FSM registers per state; internal enables ride along
  // with the datapath strobes so they all change on the same edge.
  typedef struct packed {
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic [1:0] vsel;
    logic [1:0] shift;
    logic [1:0] alu_op;
    logic [1:0] mem_cmd;
    logic       halted;
    logic       addr_sel;
    logic       load_ir;
    logic       load_pc;
    logic       load_addr;
  } ctrl_t;

endpackage

// File: rtl/cpu_controller_if.sv
// Memory port of the controller: command/address out, read data back.
// Protocol: no handshake; mem_cmd is a one-cycle command, and READ data
// appears on read_data in the cycle after the address is presented.
interface cpu_controller_if #(parameter int PC_W = 8) ();
  logic [1:0]      mem_cmd;
  logic [PC_W-1:0] mem_addr;
  logic [15:0]     read_data;

  modport master (output mem_cmd, output mem_addr, input read_data);
  modport slave  (input mem_cmd, input mem_addr, output read_data);
endinterface

// File: rtl/inst_decoder.sv
// Combinational split of the instruction register into fields and immediates.
module inst_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output dec_t        dec
);
  always_comb begin
    dec.opcode = ir[15:13];
    dec.op     = ir[12:11];
    dec.rn     = ir[10:8];
    dec.rd     = ir[7:5];
    dec.sh     = ir[4:3];
    dec.rm     = ir[2:0];
    dec.sximm8 = {{8{ir[7]}}, ir[7:0]};
    dec.sximm5 = {{11{ir[4]}}, ir[4:0]};
  end
endmodule

// File: rtl/vDFFE.sv
// Enable register with synchronous reset to a parameterised value.
module vDFFE #(
  parameter int         W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] in,
  output logic [W-1:0] out
);
  always_ff @(posedge clk) begin
    if (reset)   out <= RST_VAL;
    else if (en) out <= in;
  end
endmodule

// File: rtl/cpu_controller.sv
// Control half of the simple RISC CPU: fetch, decode and Moore sequencing of
// every datapath strobe; owns IR, PC and the data address register.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int            PC_W   = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       datapath_out,
  cpu_controller_if.master  mem,
  output logic [2:0]        readnum,
  output logic [2:0]        writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              bsel,
  output logic [1:0]        vsel,
  output logic [1:0]        shift,
  output logic [1:0]        ALUop,
  output logic [15:0]       sximm8,
  output logic [15:0]       sximm5,
  output logic [PC_W-1:0]   PC,
  output logic              halted,
  output state_t            fsm_state
);

  logic [15:0]     ir;
  logic [PC_W-1:0] data_addr;
  logic [PC_W-1:0] pc_inc;
  logic            unused_dp_hi;
  dec_t            dec;
  state_t          state, next_state;
  ctrl_t           ctrl;
  logic            is_mov_imm, is_mov_reg, is_alu, is_cmp, is_ldr, is_str;

  inst_decoder u_dec (.ir(ir), .dec(dec));

  assign pc_inc       = PC + {{(PC_W-1){1'b0}}, 1'b1};
  assign unused_dp_hi = ^datapath_out[15:PC_W];

  vDFFE #(.W(16), .RST_VAL(16'h0000)) u_ir (
    .clk(clk), .reset(reset), .en(ctrl.load_ir), .in(mem.read_data), .out(ir));
  vDFFE #(.W(PC_W), .RST_VAL(RST_PC)) u_pc (
    .clk(clk), .reset(reset), .en(ctrl.load_pc), .in(pc_inc), .out(PC));
  vDFFE #(.W(PC_W), .RST_VAL('0)) u_addr (
    .clk(clk), .reset(reset), .en(ctrl.load_addr), .in(datapath_out[PC_W-1:0]), .out(data_addr));

  assign is_mov_imm = (dec.opcode == OPC_MOV) && (dec.op == OP_MOV_IMM);
  assign is_mov_reg = (dec.opcode == OPC_MOV) && (dec.op == OP_MOV_REG);
  assign is_alu     = (dec.opcode == OPC_ALU);
  assign is_cmp     = is_alu && (dec.op == OP_CMP);
  assign is_ldr     = (dec.opcode == OPC_LDR) && (dec.op == OP_MEM);
  assign is_str     = (dec.opcode == OPC_STR) && (dec.op == OP_MEM);

  always_comb begin
    next_state = state;
    case (state)
      S_RST:       next_state = S_IF1;
      S_IF1:       next_state = S_IF2;
      S_IF2:       next_state = S_UPDATE_PC;
      S_UPDATE_PC: next_state = S_DECODE;
      S_DECODE: begin
        // HALT and every unrecognised encoding share the halt path
        if (is_mov_imm)             next_state = S_WR_IMM;
        else if (is_mov_reg)        next_state = S_GET_B;
        else if (is_alu)            next_state = (dec.op == OP_MVN) ? S_GET_B : S_GET_A;
        else if (is_ldr || is_str)  next_state = S_GET_A;
        else                        next_state = S_HALT;
      end
      S_WR_IMM:    next_state = S_IF1;
      S_GET_A:     next_state = is_alu ? S_GET_B : S_ADDR;
      S_GET_B:     next_state = S_ALU;
      S_ALU:       next_state = is_cmp ? S_IF1 : S_WR_REG;
      S_WR_REG:    next_state = S_IF1;
      S_ADDR:      next_state = S_LD_ADDR;
      S_LD_ADDR:   next_state = is_ldr ? S_RD1 : S_GET_RD;
      S_RD1:       next_state = S_RD2;
      S_RD2:       next_state = S_IF1;
      S_GET_RD:    next_state = S_PASS;
      S_PASS:      next_state = S_MEM_WR;
      S_MEM_WR:    next_state = S_IF1;
      S_HALT:      next_state = S_HALT;
      default:     next_state = S_RST;
    endcase
  end

  function automatic ctrl_t ctrl_of(state_t s, dec_t d, logic cmp, logic alu);
    ctrl_t c;
    c = '0;
    case (s)
      S_IF1:       begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; end
      S_IF2:       begin c.addr_sel = 1'b1; c.mem_cmd = MEM_READ; c.load_ir = 1'b1; end
      S_UPDATE_PC: c.load_pc = 1'b1;
      S_WR_IMM:    begin c.writenum = d.rn; c.vsel = VSEL_IMM; c.write = 1'b1; end
      S_GET_A:     begin c.readnum = d.rn; c.loada = 1'b1; end
      S_GET_B:     begin c.readnum = d.rm; c.loadb = 1'b1; end
      S_ALU: begin
        // MOV reg reuses the ALU as 0 + shifted Rm
        c.asel   = (d.opcode == OPC_MOV);
        c.alu_op = alu ? d.op : ALU_ADD;
        c.shift  = d.sh;
        c.loads  = cmp;
        c.loadc  = !cmp;
      end
      S_WR_REG:    begin c.writenum = d.rd; c.vsel = VSEL_C; c.write = 1'b1; end
      S_ADDR:      begin c.bsel = 1'b1; c.alu_op = ALU_ADD; c.loadc = 1'b1; end
      S_LD_ADDR:   c.load_addr = 1'b1;
      S_RD1:       c.mem_cmd = MEM_READ;
      S_RD2: begin
        c.mem_cmd  = MEM_READ;
        c.writenum = d.rd;
        c.vsel     = VSEL_MDATA;
        c.write    = 1'b1;
      end
      S_GET_RD:    begin c.readnum = d.rd; c.loadb = 1'b1; end
      S_PASS:      begin c.asel = 1'b1; c.alu_op = ALU_ADD; c.loadc = 1'b1; end
      S_MEM_WR:    c.mem_cmd = MEM_WRITE;
      S_HALT:      c.halted = 1'b1;
      default:     c = '0;
    endcase
    return c;
  endfunction

  // Outputs are registered alongside the state they belong to
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_RST;
      ctrl  <= '0;
    end else begin
      state <= next_state;
      ctrl  <= ctrl_of(next_state, dec, is_cmp, is_alu);
    end
  end

  assign mem.mem_cmd  = ctrl.mem_cmd;
  assign mem.mem_addr = ctrl.addr_sel ? PC : data_addr;
  assign readnum      = ctrl.readnum;
  assign writenum     = ctrl.writenum;
  assign write        = ctrl.write;
  assign loada        = ctrl.loada;
  assign loadb        = ctrl.loadb;
  assign loadc        = ctrl.loadc;
  assign loads        = ctrl.loads;
  assign asel         = ctrl.asel;
  assign bsel         = ctrl.bsel;
  assign vsel         = ctrl.vsel;
  assign shift        = ctrl.shift;
  assign ALUop        = ctrl.alu_op;
  assign halted       = ctrl.halted;
  assign sximm8       = dec.sximm8;
  assign sximm5       = dec.sximm5;
  assign fsm_state    = state;

endmodule
